// File: rtl/cmos_i2c_pkg.sv
// Shared types and constants for the PCF8583-style CMOS RAM I2C responder.
package cmos_i2c_pkg;

  localparam int RAM_DEPTH = 256;
  localparam int RAM_AW    = 8;
  localparam int RAM_DW    = 8;

  // {previous, current} synchronized SDA while SCL stays high.
  localparam logic [1:0] SDA_FALL = 2'b10;  // START
  localparam logic [1:0] SDA_RISE = 2'b01;  // STOP

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ADDR  = 4'd1,
    ACK_A = 4'd2,
    WORD  = 4'd3,
    ACK_W = 4'd4,
    WDATA = 4'd5,
    ACK_D = 4'd6,
    RDATA = 4'd7,
    RACK  = 4'd8,
    WAIT  = 4'd9
  } state_t;

endpackage

// File: rtl/cmos_ram_dp.sv
// 256x8 true dual-port RAM. Port A is the host port and wins a same-address
// write collision; reads are registered and return pre-write (old) data.
module cmos_ram_dp
  import cmos_i2c_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [RAM_AW-1:0] a_addr_i,
  input  logic              a_we_i,
  input  logic [RAM_DW-1:0] a_din_i,
  output logic [RAM_DW-1:0] a_dout_o,
  input  logic [RAM_AW-1:0] b_addr_i,
  input  logic              b_we_i,
  input  logic [RAM_DW-1:0] b_din_i,
  output logic [RAM_DW-1:0] b_dout_o
);

  logic [RAM_DW-1:0] mem_q [RAM_DEPTH];
  logic [RAM_DW-1:0] a_dout_q;
  logic [RAM_DW-1:0] b_dout_q;
  logic              b_we_eff;

  // Port B loses a same-cycle write to the same byte.
  assign b_we_eff = b_we_i & ~(a_we_i & (a_addr_i == b_addr_i));

  // Array writes; contents are deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_din_i;
    end
    if (b_we_eff) begin
      mem_q[b_addr_i] <= b_din_i;
    end
  end

  // Registered read ports, one cycle of latency, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      a_dout_q <= mem_q[a_addr_i];
      b_dout_q <= mem_q[b_addr_i];
    end
  end

  assign a_dout_o = a_dout_q;
  assign b_dout_o = b_dout_q;

endmodule

// File: rtl/cmos_i2c_slave.sv
// I2C responder emulating a PCF8583 CMOS RAM behind a bit-banged master.
// Bus handshake: the master owns SCL; this block only pulls SDA low
// (sda_o = sda_i & ~drive_low) and never stretches the clock. Bits are
// sampled on synchronized SCL rise and SDA drive changes on SCL fall.
module cmos_i2c_slave
  import cmos_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'b1010000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clkcpu,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  input  logic [7:0] host_addr,
  input  logic       host_we,
  input  logic [7:0] host_din,
  output logic [7:0] host_dout,
  output logic       busy,
  output logic [3:0] dbg_state_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        drive_low_q, drive_low_d;
  logic        busy_q, busy_d;
  logic        ack_ph_q, ack_ph_d;
  logic        rw_q, rw_d;
  logic [7:0]  shift_in;
  logic        i2c_we;
  logic [7:0]  i2c_rdata;

  // Synchronize the bus inputs and keep one extra delayed copy for edges.
  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  assign start_det = scl_s & scl_dly_q & ({sda_dly_q, sda_s} == SDA_FALL);
  assign stop_det  = scl_s & scl_dly_q & ({sda_dly_q, sda_s} == SDA_RISE);
  assign shift_in  = {shift_q[6:0], sda_s};

  // Protocol state and datapath registers.
  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      ack_ph_q    <= 1'b0;
      rw_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      ack_ph_q    <= ack_ph_d;
      rw_q        <= rw_d;
    end
  end

  // Next-state logic; STOP and START override whatever state is active.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    drive_low_d = drive_low_q;
    busy_d      = busy_q;
    ack_ph_d    = ack_ph_q;
    rw_d        = rw_q;
    i2c_we      = 1'b0;

    if (stop_det) begin
      state_d     = IDLE;
      drive_low_d = 1'b0;
      busy_d      = 1'b0;
      ack_ph_d    = 1'b0;
    end else if (start_det) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      drive_low_d = 1'b0;
      ack_ph_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, WAIT: begin
        end
        ADDR, WORD, WDATA: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == ADDR) begin
                if (shift_in[7:1] == DEV_ADDR) begin
                  state_d = ACK_A;
                  busy_d  = 1'b1;
                  rw_d    = shift_in[0];
                end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == WORD) begin
                ptr_d   = shift_in;
                state_d = ACK_W;
              end else begin
                i2c_we  = 1'b1;
                ptr_d   = ptr_q + 8'd1;
                state_d = ACK_D;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ACK_A, ACK_W, ACK_D: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              drive_low_d = 1'b1;
              ack_ph_d    = 1'b1;
            end else begin
              drive_low_d = 1'b0;
              ack_ph_d    = 1'b0;
              bit_cnt_d   = '0;
              if (state_q == ACK_A) begin
                if (rw_q) begin
                  // This fall both ends the ACK and presents the MSB.
                  state_d     = RDATA;
                  shift_d     = i2c_rdata;
                  drive_low_d = ~i2c_rdata[7];
                  bit_cnt_d   = 4'd1;
                end else begin
                  state_d = WORD;
                end
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          // bit_cnt counts bits already presented; 8 means release for ACK.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              drive_low_d = 1'b0;
              ptr_d       = ptr_q + 8'd1;
              bit_cnt_d   = '0;
              state_d     = RACK;
            end else if (bit_cnt_q == 4'd0) begin
              drive_low_d = ~shift_q[7];
              bit_cnt_d   = 4'd1;
            end else begin
              shift_d     = {shift_q[6:0], 1'b0};
              drive_low_d = ~shift_q[6];
              bit_cnt_d   = bit_cnt_q + 4'd1;
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              state_d   = RDATA;
              shift_d   = i2c_rdata;
              bit_cnt_d = '0;
            end else begin
              state_d = WAIT;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  cmos_ram_dp u_ram (
    .clk_i    (clkcpu),
    .rst_i    (rst_i),
    .a_addr_i (host_addr),
    .a_we_i   (host_we),
    .a_din_i  (host_din),
    .a_dout_o (host_dout),
    .b_addr_i (ptr_q),
    .b_we_i   (i2c_we),
    .b_din_i  (shift_in),
    .b_dout_o (i2c_rdata)
  );

  assign sda_o       = sda_i & ~drive_low_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cmos_i2c_slave.sv
// Bench for cmos_i2c_slave: directed table and sequences plus random I2C
// transactions checked against a byte-array model of the CMOS RAM.
module tb_cmos_i2c_slave;
  import cmos_i2c_pkg::*;

  localparam int H = 8;  // SCL half period in clkcpu cycles
  localparam int Q = 4;  // hold after SCL fall before SDA changes

  logic       clkcpu = 1'b0;
  logic       rst_i;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic [7:0] host_addr;
  logic       host_we;
  logic [7:0] host_din;
  logic [7:0] host_dout;
  logic       busy;
  logic [3:0] dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clkcpu = ~clkcpu;

  cmos_i2c_slave dut (
    .clkcpu      (clkcpu),
    .rst_i       (rst_i),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .sda_o       (sda_o),
    .host_addr   (host_addr),
    .host_we     (host_we),
    .host_din    (host_din),
    .host_dout   (host_dout),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr;
  logic [7:0] exp_q [$];
  int         ack_lat;
  bit         follow_err;
  bit         collide_en = 1'b0;
  logic [7:0] collide_addr;
  logic [7:0] collide_data;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } hv_t;
  hv_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkcpu);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_addr = a; host_din = d; host_we = 1'b1;
    tick(1);
    host_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    host_addr = a;
    tick(1);
    d = host_dout;
  endtask

  task automatic i2c_start();
    if (scl_i == 1'b0) begin
      sda_i = 1'b1; tick(H);
      scl_i = 1'b1; tick(H);
    end
    sda_i = 1'b0; tick(H);
    scl_i = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_i = 1'b0; tick(H);
    scl_i = 1'b1; tick(H);
    sda_i = 1'b1; tick(H);
  endtask

  task automatic i2c_write_byte(input logic [7:0] b, output bit ack);
    follow_err = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sda_i = b[i]; tick(H);
      scl_i = 1'b1;
      if (collide_en && i == 0) begin
        tick(2);
        host_addr = collide_addr; host_din = collide_data; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        tick(H - 3);
      end else begin
        tick(H);
      end
      scl_i = 1'b0;
      if (i == 0) begin
        sda_i   = 1'b1;
        ack_lat = 0;
        for (int k = 1; k <= 8; k++) begin
          tick(1);
          if (sda_o !== sda_i) follow_err = 1'b1;
          if (ack_lat == 0 && sda_o == 1'b0) ack_lat = k;
        end
      end else begin
        tick(Q);
      end
    end
    scl_i = 1'b1; tick(H / 2);
    ack = (sda_o == 1'b0);
    if (sda_o !== sda_i) follow_err = 1'b1;
    tick(H / 2);
    scl_i = 1'b0; tick(Q);
  endtask

  task automatic i2c_read_byte(input bit ack, output logic [7:0] d);
    sda_i = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(H);
      scl_i = 1'b1; tick(H / 2);
      d[i] = sda_o;
      tick(H / 2);
      scl_i = 1'b0; tick(Q);
    end
    sda_i = ack ? 1'b0 : 1'b1; tick(H);
    scl_i = 1'b1; tick(H);
    scl_i = 1'b0; sda_i = 1'b1; tick(Q);
  endtask

  task automatic send(input logic [7:0] b, input string nm);
    bit a;
    i2c_write_byte(b, a);
    check(nm, a, 1);
  endtask

  task automatic write_seq(input int n);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      model_mem[model_ptr] = d;
      model_ptr = model_ptr + 8'd1;
      send(d, "wdata_ack");
    end
  endtask

  task automatic read_seq(input int n);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_mem[model_ptr]);
      model_ptr = model_ptr + 8'd1;
      i2c_read_byte(k < n - 1, d);
      check("i2c_rd", d, exp_q.pop_front());
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    n_checks++;
    $display("FAIL watchdog: time limit reached before end of test");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- test ----------------
  initial begin
    logic [7:0] r;
    logic [7:0] p;
    bit         a;
    int         n;

    tbl[0] = '{8'h40, 8'h5A};
    tbl[1] = '{8'h10, 8'hA5};
    tbl[2] = '{8'h00, 8'hFF};
    tbl[3] = '{8'hFF, 8'h01};
    tbl[4] = '{8'h80, 8'h3C};
    tbl[5] = '{8'h7F, 8'hC3};

    rst_i = 1'b1; scl_i = 1'b1; sda_i = 1'b1;
    host_we = 1'b0; host_addr = '0; host_din = '0;
    tick(4);
    check("rst_sda", sda_o, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_host_dout", host_dout, 8'h00);
    check("rst_state", dbg_state, IDLE);
    rst_i = 1'b0;
    tick(2);
    model_ptr = 8'h00;

    // Boot preload of the whole RAM through the host port.
    for (int i = 0; i < 256; i++) host_write(8'(i), 8'($urandom));

    // Table: host writes then host reads back with one-cycle latency.
    for (int i = 0; i < 6; i++) host_write(tbl[i].addr, tbl[i].data);
    for (int i = 0; i < 6; i++) begin
      host_read(tbl[i].addr, r);
      check("tbl_host_rd", r, tbl[i].data);
    end

    // Random read of 0x40 over I2C; ACK lands 3 cycles after SCL fall.
    i2c_start();
    send(8'hA0, "addr_ack");
    check("ack_latency", ack_lat, 3);
    check("busy_after_addr", busy, 1'b1);
    send(8'h40, "word_ack");
    model_ptr = 8'h40;
    i2c_start();
    send(8'hA1, "raddr_ack");
    read_seq(1);
    i2c_stop();
    check("busy_after_stop", busy, 1'b0);
    check("idle_after_stop", dbg_state, IDLE);

    // Wrong address: no ACK, bus untouched, next START accepted.
    i2c_start();
    i2c_write_byte(8'hA2, a);
    check("wrong_addr_nack", a, 0);
    check("wrong_addr_follow", follow_err, 0);
    check("wrong_addr_state", dbg_state, IDLE);
    check("wrong_addr_busy", busy, 1'b0);
    i2c_start();
    send(8'hA0, "addr_after_wrong");
    i2c_stop();

    // Write with pointer wrap, then read back by host and by I2C.
    i2c_start();
    send(8'hA0, "addr_ack");
    send(8'hFE, "word_ack");
    send(8'h11, "wdata_ack");
    send(8'h22, "wdata_ack");
    send(8'h33, "wdata_ack");
    i2c_stop();
    model_mem[8'hFE] = 8'h11; model_mem[8'hFF] = 8'h22; model_mem[8'h00] = 8'h33;
    model_ptr = 8'h01;
    host_read(8'hFE, r); check("wrap_fe", r, 8'h11);
    host_read(8'hFF, r); check("wrap_ff", r, 8'h22);
    host_read(8'h00, r); check("wrap_00", r, 8'h33);
    i2c_start();
    send(8'hA0, "addr_ack");
    send(8'hFE, "word_ack");
    model_ptr = 8'hFE;
    i2c_start();
    send(8'hA1, "raddr_ack");
    read_seq(3);
    i2c_stop();

    // Abort after 4 data bits: no write, pointer stays at word value.
    i2c_start();
    send(8'hA0, "addr_ack");
    send(8'h30, "word_ack");
    model_ptr = 8'h30;
    for (int i = 0; i < 4; i++) begin
      sda_i = ~model_mem[8'h30][7 - i]; tick(H);
      scl_i = 1'b1; tick(H);
      scl_i = 1'b0; tick(Q);
    end
    i2c_stop();
    check("abort_sda", sda_o, sda_i);
    check("abort_busy", busy, 1'b0);
    check("abort_state", dbg_state, IDLE);
    host_read(8'h30, r);
    check("abort_ram", r, model_mem[8'h30]);
    i2c_start();
    send(8'hA1, "raddr_ack");
    read_seq(1);
    i2c_stop();

    // Same-cycle host and I2C write to 0x10: host value stored.
    i2c_start();
    send(8'hA0, "addr_ack");
    send(8'h10, "word_ack");
    collide_en = 1'b1; collide_addr = 8'h10; collide_data = 8'hC3;
    send(8'h77, "wdata_ack");
    collide_en = 1'b0;
    i2c_stop();
    model_mem[8'h10] = 8'hC3;
    host_read(8'h10, r);
    check("collision_host_wins", r, 8'hC3);

    // Reset while the slave is driving a 0 data bit.
    host_write(8'h55, 8'h00);
    i2c_start();
    send(8'hA0, "addr_ack");
    send(8'h55, "word_ack");
    i2c_start();
    send(8'hA1, "raddr_ack");
    tick(2);
    check("mid_read_driving", sda_o, 1'b0);
    rst_i = 1'b1;
    tick(1);
    check("mid_read_rst_sda", sda_o, 1'b1);
    check("mid_read_rst_state", dbg_state, IDLE);
    check("mid_read_rst_busy", busy, 1'b0);
    rst_i = 1'b0;
    tick(2);
    model_ptr = 8'h00;
    i2c_stop();
    host_read(8'h55, r);
    check("mid_read_ram_kept", r, 8'h00);

    // Random transactions against the model.
    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(0, 3))
        0: begin
          p = 8'($urandom); n = $urandom_range(1, 4);
          i2c_start();
          send(8'hA0, "addr_ack");
          send(p, "word_ack");
          model_ptr = p;
          write_seq(n);
          i2c_stop();
          check("rand_wr_busy", busy, 1'b0);
        end
        1: begin
          p = 8'($urandom); n = $urandom_range(1, 4);
          i2c_start();
          send(8'hA0, "addr_ack");
          send(p, "word_ack");
          model_ptr = p;
          i2c_start();
          send(8'hA1, "raddr_ack");
          read_seq(n);
          i2c_stop();
        end
        2: begin
          n = $urandom_range(1, 3);
          i2c_start();
          send(8'hA1, "raddr_ack");
          read_seq(n);
          i2c_stop();
        end
        default: begin
          host_write(8'($urandom), 8'($urandom));
          p = 8'($urandom);
          host_read(p, r);
          check("rand_host_rd", r, model_mem[p]);
        end
      endcase
    end

    for (int i = 0; i < 8; i++) begin
      p = 8'($urandom);
      host_read(p, r);
      check("final_host_rd", r, model_mem[p]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
